// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// The master side is a requester pair; the slave side is the arbiter.
interface alu_share_arbiter_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 4
);
    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [OPW-1:0]  req0_op;
    logic [OPW-1:0]  req1_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req0_b;
    logic [XLEN-1:0] req1_b;
    logic            rsp0_valid;
    logic            rsp1_valid;
    logic            rsp0_ready;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_err;
    logic            busy;

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req1_a, req0_b, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req1_a, req0_b, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and IDLE/ISSUE/RESP sequencer for the shared 64-bit ALU.
// One operation is in flight at a time; the result register is shared by both response channels.
module alu_share_arbiter #(
    parameter int XLEN = 64,
    parameter int OPW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q;
    logic            owner_q;
    logic            gnt0, gnt1, accept, rsp_take;
    logic [OPW-1:0]  op_p0;
    logic [XLEN-1:0] a_p0, b_p0;
    logic [XLEN-1:0] result_p1;
    logic            err_p1;
    logic [XLEN:0]   alu_out;

    // Returns {err, result}; illegal opcodes yield a zero result with err set.
    function automatic logic [XLEN:0] alu_eval(input logic [OPW-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [5:0]             sh;
        logic [XLEN-1:0]        res;
        logic                   err;
        sa  = a;
        sb  = b;
        sh  = b[5:0];
        res = '0;
        err = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = sa >>> sh;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            default: err = 1'b1;
        endcase
        return {err, res};
    endfunction

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        gnt0 = bus.req0_valid && !gnt1;
    end

    assign rsp_take = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    bus.req0_ready = gnt0;
                    bus.req1_ready = gnt1;
                    accept         = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= gnt1;
                last_grant_q <= gnt1;
            end
        end
    end

    // Stage p0: operands latched at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= gnt1 ? bus.req1_op : bus.req0_op;
            a_p0  <= gnt1 ? bus.req1_a  : bus.req0_a;
            b_p0  <= gnt1 ? bus.req1_b  : bus.req0_b;
        end
    end

    assign alu_out = alu_eval(op_p0, a_p0, b_p0);

    // Stage p1: result captured in ISSUE, held through RESP until the next ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            err_p1    <= 1'b0;
        end else if (state_q == ISSUE) begin
            result_p1 <= alu_out[XLEN-1:0];
            err_p1    <= alu_out[XLEN];
        end
    end

    assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
    assign bus.rsp_result = result_p1;
    assign bus.rsp_err    = err_p1;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: arbitration, latency, ALU results, back-pressure and reset abort.
module tb_alu_share_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_share_arbiter_if #(.XLEN(64), .OPW(4)) bus ();

    alu_share_arbiter #(.XLEN(64), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Single uncontended operation from IDLE with response ready held high.
    task automatic do_op(input string tag, input int r, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input logic exp_err);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive(r, 1'b1, op, a, b);
        #1;
        chk({tag, "_ready"}, 64'(r == 0 ? bus.req0_ready : bus.req1_ready), 64'd1);
        tick();
        drive(r, 1'b0, 4'd0, '0, '0);
        chk({tag, "_issue_busy"}, 64'(bus.busy), 64'd1);
        tick();
        chk({tag, "_rsp_valid"}, 64'(r == 0 ? bus.rsp0_valid : bus.rsp1_valid), 64'd1);
        chk({tag, "_other_valid"}, 64'(r == 0 ? bus.rsp1_valid : bus.rsp0_valid), 64'd0);
        chk({tag, "_result"}, bus.rsp_result, exp);
        chk({tag, "_err"}, 64'(bus.rsp_err), 64'(exp_err));
        tick();
        chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick();
        tick();
        chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
        chk("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
        chk("rst_result", bus.rsp_result, 64'd0);
        chk("rst_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        tick();

        do_op("add_wrap", 0, 4'd0, ONES, 64'd1, 64'd0, 1'b0);

        // Tie from reset: req0 first, then req1, then req0 again.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive(0, 1'b1, 4'd1, 64'd5, 64'd7);
        drive(1, 1'b1, 4'd8, ONES, 64'd0);
        #1;
        chk("tie1_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("tie1_req1_ready", 64'(bus.req1_ready), 64'd0);
        tick();
        chk("tie1_issue_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        tick();
        chk("tie1_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
        chk("tie1_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
        chk("tie1_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("tie1_resp_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        tick();
        chk("tie2_req0_ready", 64'(bus.req0_ready), 64'd0);
        chk("tie2_req1_ready", 64'(bus.req1_ready), 64'd1);
        tick();
        tick();
        chk("tie2_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
        chk("tie2_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        chk("tie2_result", bus.rsp_result, 64'd1);
        tick();
        chk("tie3_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("tie3_req1_ready", 64'(bus.req1_ready), 64'd0);
        tick();
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        tick();
        chk("tie3_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();

        do_op("sra", 0, 4'd7, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0);
        do_op("srl", 1, 4'd6, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0);
        do_op("sltu", 0, 4'd9, 64'd1, ONES, 64'd1, 1'b0);
        do_op("sll", 1, 4'd5, 64'd1, 64'h7F, 64'h8000_0000_0000_0000, 1'b0);
        do_op("slt_pos", 1, 4'd8, 64'd3, ONES, 64'd0, 1'b0);

        // Back-pressure on requester 1 while requester 0 waits.
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b0;
        drive(1, 1'b1, 4'd4, 64'hFF00, 64'h0FF0);
        #1;
        chk("bp_req1_ready", 64'(bus.req1_ready), 64'd1);
        tick();
        drive(1, 1'b0, 4'd0, '0, '0);
        drive(0, 1'b1, 4'd0, 64'd2, 64'd3);
        #1;
        chk("bp_issue_req0_ready", 64'(bus.req0_ready), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
            chk("bp_result", bus.rsp_result, 64'hF0F0);
            chk("bp_req0_ready", 64'(bus.req0_ready), 64'd0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", 64'(bus.req0_ready), 64'd0);
        tick();
        chk("bp_idle_req0_ready", 64'(bus.req0_ready), 64'd1);
        tick();
        drive(0, 1'b0, 4'd0, '0, '0);
        tick();
        chk("bp_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
        chk("bp_add_result", bus.rsp_result, 64'd5);
        tick();

        do_op("illegal", 0, 4'd12, 64'h1234, 64'h1234, 64'd0, 1'b1);
        do_op("and", 0, 4'd2, 64'h1234, 64'h0F0F, 64'h0204, 1'b0);

        // Reset while in RESP aborts the operation.
        bus.rsp0_ready = 1'b0;
        drive(0, 1'b1, 4'd0, 64'd10, 64'd20);
        tick();
        drive(0, 1'b0, 4'd0, '0, '0);
        tick();
        chk("abort_rsp0_valid_pre", 64'(bus.rsp0_valid), 64'd1);
        chk("abort_result_pre", bus.rsp_result, 64'd30);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_result", bus.rsp_result, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(0, 1'b1, 4'd1, 64'd1, 64'd1);
        drive(1, 1'b1, 4'd1, 64'd1, 64'd1);
        #1;
        chk("abort_tie_req0_ready", 64'(bus.req0_ready), 64'd1);
        chk("abort_tie_req1_ready", 64'(bus.req1_ready), 64'd0);
        drive(0, 1'b0, 4'd0, '0, '0);
        drive(1, 1'b0, 4'd0, '0, '0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
